// File: rtl/acc_id_reorder.sv
// Sequential ID allocator plus reorder buffer: tags core requests with circular IDs and
// releases out-of-order interconnect responses back to the core strictly in issue order.
package acc_id_reorder_pkg;
  localparam int unsigned IdW   = 5;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;

  typedef struct packed {
    logic [AddrW-1:0] addr;
    logic [DataW-1:0] data;
    logic [IdW-1:0]   id;
  } req_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             error;
    logic [IdW-1:0]   id;
  } rsp_chan_t;

  typedef struct packed {
    req_chan_t q;
    logic      q_valid;
    logic      p_ready;
  } req_t;

  typedef struct packed {
    rsp_chan_t p;
    logic      p_valid;
    logic      q_ready;
  } rsp_t;
endpackage

module acc_id_reorder
  import acc_id_reorder_pkg::*;
#(
  parameter int unsigned NumIds = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  req_chan_t                 core_q_i,
  input  logic                      core_q_valid_i,
  output logic                      core_q_ready_o,
  output rsp_chan_t                 core_p_o,
  output logic                      core_p_valid_o,
  input  logic                      core_p_ready_i,
  output req_t                      acc_req_o,
  input  rsp_t                      acc_rsp_i,
  output logic [$clog2(NumIds):0]   outstanding_o,
  output logic                      err_o
);

  localparam int unsigned IdxW   = $clog2(NumIds);
  localparam int unsigned CntW   = IdxW + 1;
  localparam int unsigned RangeW = IdW + 1;

  logic [IdxW-1:0]   head_q;
  logic [IdxW-1:0]   tail_q;
  logic [CntW-1:0]   count_q;
  logic [NumIds-1:0] alloc_q;
  logic [NumIds-1:0] slot_vld_q;
  rsp_chan_t         slot_q [NumIds];
  logic              err_q;

  logic              full;
  logic              alloc_fire;
  logic              retire_fire;
  logic              rsp_in_range;
  logic [IdxW-1:0]   rsp_idx;
  logic              rsp_ok;
  logic              rsp_err;

  assign full        = (count_q == CntW'(NumIds));
  assign alloc_fire  = core_q_valid_i & acc_rsp_i.q_ready & ~full;
  assign retire_fire = slot_vld_q[head_q] & core_p_ready_i;

  // A response is accepted only for an allocated ID that has not answered yet.
  assign rsp_in_range = ({1'b0, acc_rsp_i.p.id} < RangeW'(NumIds));
  assign rsp_idx      = acc_rsp_i.p.id[IdxW-1:0];
  assign rsp_ok       = acc_rsp_i.p_valid & rsp_in_range & alloc_q[rsp_idx] & ~slot_vld_q[rsp_idx];
  assign rsp_err      = acc_rsp_i.p_valid & ~rsp_ok;

  // Request path is a pure pass-through with the ID overwritten by the tail pointer.
  always_comb begin
    acc_req_o         = '0;
    acc_req_o.q       = core_q_i;
    acc_req_o.q.id    = IdW'(tail_q);
    acc_req_o.q_valid = core_q_valid_i & ~full;
    acc_req_o.p_ready = 1'b1;
  end

  assign core_q_ready_o = acc_rsp_i.q_ready & ~full;

  always_comb begin
    core_p_o    = slot_q[head_q];
    core_p_o.id = IdW'(head_q);
  end

  assign core_p_valid_o = slot_vld_q[head_q];
  assign outstanding_o  = count_q;
  assign err_o          = err_q;

  // Pointer, occupancy and per-slot status tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      alloc_q    <= '0;
      slot_vld_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (alloc_fire) begin
        alloc_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + IdxW'(1);
      end
      if (retire_fire) begin
        alloc_q[head_q]    <= 1'b0;
        slot_vld_q[head_q] <= 1'b0;
        head_q             <= head_q + IdxW'(1);
      end
      // A capture never targets the retiring head: head already holds a valid slot.
      if (rsp_ok) begin
        slot_vld_q[rsp_idx] <= 1'b1;
      end
      if (rsp_err) begin
        err_q <= 1'b1;
      end
      case ({alloc_fire, retire_fire})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Response payload storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (rsp_ok) begin
      slot_q[rsp_idx] <= acc_rsp_i.p;
    end
  end

endmodule

// File: tb/tb_acc_id_reorder.sv
// Randomized bench for acc_id_reorder against a queue-based model of issue order and responses.
module tb_acc_id_reorder;
  import acc_id_reorder_pkg::*;

  localparam int unsigned NumIds = 8;
  localparam int unsigned CntW   = $clog2(NumIds) + 1;

  logic            clk_i;
  logic            rst_ni;
  req_chan_t       core_q_i;
  logic            core_q_valid_i;
  logic            core_q_ready_o;
  rsp_chan_t       core_p_o;
  logic            core_p_valid_o;
  logic            core_p_ready_i;
  req_t            acc_req_o;
  rsp_t            acc_rsp_i;
  logic [CntW-1:0] outstanding_o;
  logic            err_o;

  int total;
  int bad;

  // Model: issue-ordered queue of live IDs, which of them have answered, and their payloads.
  int        m_q[$];
  bit        m_have[NumIds];
  rsp_chan_t m_data[NumIds];
  int        m_tail;
  bit        m_err;

  acc_id_reorder #(.NumIds(NumIds)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .core_q_i       (core_q_i),
    .core_q_valid_i (core_q_valid_i),
    .core_q_ready_o (core_q_ready_o),
    .core_p_o       (core_p_o),
    .core_p_valid_o (core_p_valid_o),
    .core_p_ready_i (core_p_ready_i),
    .acc_req_o      (acc_req_o),
    .acc_rsp_i      (acc_rsp_i),
    .outstanding_o  (outstanding_o),
    .err_o          (err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < NumIds; i++) m_have[i] = 1'b0;
    m_tail = 0;
    m_err  = 1'b0;
  endtask

  function automatic bit m_pending(int k);
    foreach (m_q[i]) if (m_q[i] == k) return !m_have[k];
    return 1'b0;
  endfunction

  // Advance one clock, updating the model from the inputs present before the edge.
  task automatic tick();
    bit do_alloc, do_ret, do_cap;
    int k, r;
    do_alloc = core_q_valid_i && acc_rsp_i.q_ready && (m_q.size() < NumIds);
    do_ret   = (m_q.size() > 0) && m_have[m_q[0]] && core_p_ready_i;
    do_cap   = 1'b0;
    k        = int'(acc_rsp_i.p.id);
    if (rst_ni) begin
      if (acc_rsp_i.p_valid) begin
        if (k < NumIds && m_pending(k)) do_cap = 1'b1;
        else m_err = 1'b1;
      end
      if (do_cap) begin
        m_have[k] = 1'b1;
        m_data[k] = acc_rsp_i.p;
      end
      if (do_ret) begin
        r = m_q.pop_front();
        m_have[r] = 1'b0;
      end
      if (do_alloc) begin
        m_q.push_back(m_tail);
        m_tail = (m_tail + 1) % NumIds;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_idle();
    core_q_valid_i     = 1'b0;
    core_p_ready_i     = 1'b0;
    core_q_i           = '0;
    acc_rsp_i          = '0;
    acc_rsp_i.q_ready  = 1'b1;
  endtask

  task automatic rand_req();
    core_q_i.addr = $urandom;
    core_q_i.data = $urandom;
    core_q_i.id   = 5'($urandom);
  endtask

  task automatic send_rsp(int k);
    acc_rsp_i.p_valid = 1'b1;
    acc_rsp_i.p.id    = 5'(k);
    acc_rsp_i.p.data  = $urandom;
    acc_rsp_i.p.error = 1'($urandom);
  endtask

  task automatic issue(int n);
    for (int i = 0; i < n; i++) begin
      drive_idle();
      core_q_valid_i = 1'b1;
      rand_req();
      tick();
    end
    drive_idle();
  endtask

  // Answer and retire everything outstanding, in random response order.
  task automatic drain();
    int pend[$];
    for (int c = 0; c < 400 && m_q.size() > 0; c++) begin
      drive_idle();
      core_p_ready_i = 1'b1;
      pend.delete();
      foreach (m_q[i]) if (!m_have[m_q[i]]) pend.push_back(m_q[i]);
      if (pend.size() > 0 && $urandom_range(0, 2) != 0)
        send_rsp(pend[$urandom_range(0, pend.size() - 1)]);
      tick();
    end
    drive_idle();
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b1;
    drive_idle();
    #2;
    rst_ni = 1'b0;
    model_reset();
    core_q_valid_i = 1'b1;
    rand_req();
    tick();
    tick();
    total++;
    if (core_p_valid_o !== 1'b0 || outstanding_o !== '0 || err_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state got pv=%0b out=%0d err=%0b want 0/0/0", core_p_valid_o, outstanding_o, err_o);
    end
    total++;
    if (acc_req_o.p_ready !== 1'b1 || acc_req_o.q_valid !== 1'b1 || acc_req_o.q.id !== 5'd0) begin
      bad++;
      $display("FAIL reset_req got p_ready=%0b q_valid=%0b id=%0d want 1/1/0",
               acc_req_o.p_ready, acc_req_o.q_valid, acc_req_o.q.id);
    end
    drive_idle();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_out_of_order();
    int        order[3] = '{2, 0, 1};
    bit        pv_t[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int        id_t[6]  = '{0, 0, 0, 1, 2, 0};
    int        cnt_t[6] = '{3, 3, 3, 2, 1, 0};
    rsp_chan_t sent[3];
    rsp_chan_t exp;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      core_q_valid_i = 1'b1;
      rand_req();
      #1;
      total++;
      if (acc_req_o.q_valid !== 1'b1 || acc_req_o.q.id !== 5'(i) ||
          acc_req_o.q.addr !== core_q_i.addr || acc_req_o.q.data !== core_q_i.data) begin
        bad++;
        $display("FAIL ooo_issue %0d got valid=%0b id=%0d want 1/%0d", i, acc_req_o.q_valid, acc_req_o.q.id, i);
      end
      tick();
    end
    for (int c = 0; c < 6; c++) begin
      drive_idle();
      core_p_ready_i = 1'b1;
      if (c < 3) begin
        send_rsp(order[c]);
        sent[order[c]] = acc_rsp_i.p;
      end
      #1;
      total++;
      if (core_p_valid_o !== pv_t[c] || outstanding_o !== CntW'(cnt_t[c])) begin
        bad++;
        $display("FAIL ooo_cycle %0d got pv=%0b out=%0d want %0b/%0d", c, core_p_valid_o, outstanding_o, pv_t[c], cnt_t[c]);
      end
      if (pv_t[c]) begin
        exp    = sent[id_t[c]];
        exp.id = 5'(id_t[c]);
        total++;
        if (core_p_o !== exp) begin
          bad++;
          $display("FAIL ooo_data %0d got %h want %h", c, core_p_o, exp);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_wrap();
    int first;
    first = m_tail;
    for (int i = 0; i < NumIds; i++) begin
      drive_idle();
      core_q_valid_i = 1'b1;
      rand_req();
      #1;
      total++;
      if (core_q_ready_o !== 1'b1 || acc_req_o.q.id !== 5'((first + i) % NumIds)) begin
        bad++;
        $display("FAIL fill_%0d got ready=%0b id=%0d want 1/%0d", i, core_q_ready_o, acc_req_o.q.id, (first + i) % NumIds);
      end
      tick();
    end
    core_q_valid_i = 1'b1;
    #1;
    total++;
    if (core_q_ready_o !== 1'b0 || acc_req_o.q_valid !== 1'b0 || outstanding_o !== CntW'(NumIds)) begin
      bad++;
      $display("FAIL full_stall got ready=%0b qv=%0b out=%0d want 0/0/%0d", core_q_ready_o, acc_req_o.q_valid, outstanding_o, NumIds);
    end
    tick();
    send_rsp(first);
    tick();
    acc_rsp_i.p_valid = 1'b0;
    core_p_ready_i    = 1'b1;
    #1;
    total++;
    if (core_q_ready_o !== 1'b0 || core_p_valid_o !== 1'b1 || core_p_o.id !== 5'(first)) begin
      bad++;
      $display("FAIL full_retire got ready=%0b pv=%0b id=%0d want 0/1/%0d", core_q_ready_o, core_p_valid_o, core_p_o.id, first);
    end
    tick();
    core_p_ready_i = 1'b0;
    #1;
    total++;
    if (core_q_ready_o !== 1'b1 || acc_req_o.q.id !== 5'(first) || outstanding_o !== CntW'(NumIds - 1)) begin
      bad++;
      $display("FAIL full_reuse got ready=%0b id=%0d out=%0d want 1/%0d/%0d", core_q_ready_o, acc_req_o.q.id, outstanding_o, first, NumIds - 1);
    end
    tick();
    core_q_valid_i = 1'b0;
    #1;
    total++;
    if (outstanding_o !== CntW'(NumIds)) begin
      bad++;
      $display("FAIL full_refill got out=%0d want %0d", outstanding_o, NumIds);
    end
    drain();
    total++;
    if (outstanding_o !== '0 || m_q.size() != 0) begin
      bad++;
      $display("FAIL full_drain got out=%0d model=%0d want 0", outstanding_o, m_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int        start;
    rsp_chan_t exp;
    issue(4);
    for (int i = 0; i < 4; i++) begin
      drive_idle();
      send_rsp(m_q[i]);
      tick();
    end
    start = m_tail;
    for (int c = 0; c < 20; c++) begin
      drive_idle();
      core_q_valid_i = 1'b1;
      rand_req();
      core_p_ready_i = 1'b1;
      if (!m_have[m_q[m_q.size() - 1]]) send_rsp(m_q[m_q.size() - 1]);
      #1;
      exp    = m_data[m_q[0]];
      exp.id = 5'(m_q[0]);
      total++;
      if (acc_req_o.q.id !== 5'((start + c) % NumIds) || core_q_ready_o !== 1'b1 ||
          core_p_valid_o !== 1'b1 || outstanding_o !== CntW'(4) || core_p_o !== exp) begin
        bad++;
        $display("FAIL b2b_%0d got id=%0d rdy=%0b pv=%0b out=%0d p=%h want %0d/1/1/4/%h",
                 c, acc_req_o.q.id, core_q_ready_o, core_p_valid_o, outstanding_o, core_p_o,
                 (start + c) % NumIds, exp);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_backpressure();
    int        ids[$];
    int        j, t;
    rsp_chan_t exp;
    issue(NumIds);
    ids = m_q;
    for (int i = NumIds - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = ids[i]; ids[i] = ids[j]; ids[j] = t;
    end
    foreach (ids[i]) begin
      drive_idle();
      send_rsp(ids[i]);
      tick();
    end
    exp    = m_data[m_q[0]];
    exp.id = 5'(m_q[0]);
    for (int c = 0; c < 6; c++) begin
      drive_idle();
      core_q_valid_i = 1'b1;
      rand_req();
      #1;
      total++;
      if (core_p_valid_o !== 1'b1 || core_p_o !== exp || acc_req_o.p_ready !== 1'b1 ||
          acc_req_o.q_valid !== 1'b0 || outstanding_o !== CntW'(NumIds)) begin
        bad++;
        $display("FAIL bp_%0d got pv=%0b p=%h pr=%0b qv=%0b out=%0d want 1/%h/1/0/%0d",
                 c, core_p_valid_o, core_p_o, acc_req_o.p_ready, acc_req_o.q_valid, outstanding_o, exp, NumIds);
      end
      tick();
    end
    drain();
  endtask

  task automatic test_random();
    int        pend[$];
    bit        exp_pv;
    rsp_chan_t exp;
    for (int c = 0; c < 400; c++) begin
      drive_idle();
      core_q_valid_i    = ($urandom_range(0, 3) != 0);
      rand_req();
      core_p_ready_i    = ($urandom_range(0, 2) != 0);
      acc_rsp_i.q_ready = ($urandom_range(0, 4) != 0);
      pend.delete();
      foreach (m_q[i]) if (!m_have[m_q[i]]) pend.push_back(m_q[i]);
      if (pend.size() > 0 && $urandom_range(0, 1) != 0)
        send_rsp(pend[$urandom_range(0, pend.size() - 1)]);
      #1;
      exp_pv = (m_q.size() > 0) && m_have[m_q[0]];
      total++;
      if (core_p_valid_o !== exp_pv || outstanding_o !== CntW'(m_q.size()) || err_o !== m_err) begin
        bad++;
        $display("FAIL rnd_state %0d got pv=%0b out=%0d err=%0b want %0b/%0d/%0b",
                 c, core_p_valid_o, outstanding_o, err_o, exp_pv, m_q.size(), m_err);
      end
      total++;
      if (acc_req_o.q_valid !== (core_q_valid_i && m_q.size() < NumIds) ||
          core_q_ready_o !== (acc_rsp_i.q_ready && m_q.size() < NumIds) ||
          acc_req_o.q.id !== 5'(m_tail) || acc_req_o.q.addr !== core_q_i.addr) begin
        bad++;
        $display("FAIL rnd_req %0d got qv=%0b rdy=%0b id=%0d want id=%0d size=%0d",
                 c, acc_req_o.q_valid, core_q_ready_o, acc_req_o.q.id, m_tail, m_q.size());
      end
      if (exp_pv) begin
        exp    = m_data[m_q[0]];
        exp.id = 5'(m_q[0]);
        total++;
        if (core_p_o !== exp) begin
          bad++;
          $display("FAIL rnd_data %0d got %h want %h", c, core_p_o, exp);
        end
      end
      tick();
    end
    drain();
  endtask

  task automatic test_error();
    int        a, b;
    rsp_chan_t ra, rb, exp;
    #1;
    total++;
    if (err_o !== 1'b0) begin
      bad++;
      $display("FAIL err_clean got %0b want 0", err_o);
    end
    a = m_tail;
    b = (m_tail + 1) % NumIds;
    issue(2);
    send_rsp((a + 5) % NumIds);
    tick();
    drive_idle();
    #1;
    total++;
    if (err_o !== 1'b1 || core_p_valid_o !== 1'b0 || outstanding_o !== CntW'(2)) begin
      bad++;
      $display("FAIL err_unalloc got err=%0b pv=%0b out=%0d want 1/0/2", err_o, core_p_valid_o, outstanding_o);
    end
    send_rsp(b);
    rb = acc_rsp_i.p;
    tick();
    send_rsp(b);
    acc_rsp_i.p.data = ~rb.data;
    tick();
    drive_idle();
    send_rsp(NumIds + 3);
    tick();
    send_rsp(a);
    ra = acc_rsp_i.p;
    tick();
    drive_idle();
    core_p_ready_i = 1'b1;
    #1;
    exp    = ra;
    exp.id = 5'(a);
    total++;
    if (core_p_valid_o !== 1'b1 || core_p_o !== exp || err_o !== 1'b1) begin
      bad++;
      $display("FAIL err_first got pv=%0b p=%h err=%0b want 1/%h/1", core_p_valid_o, core_p_o, err_o, exp);
    end
    tick();
    exp    = rb;
    exp.id = 5'(b);
    total++;
    if (core_p_valid_o !== 1'b1 || core_p_o !== exp) begin
      bad++;
      $display("FAIL err_dup_kept got pv=%0b p=%h want 1/%h", core_p_valid_o, core_p_o, exp);
    end
    tick();
    drive_idle();
    tick();
    total++;
    if (err_o !== 1'b1 || outstanding_o !== '0 || core_p_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL err_sticky got err=%0b out=%0d pv=%0b want 1/0/0", err_o, outstanding_o, core_p_valid_o);
    end
  endtask

  task automatic test_reset_mid();
    int pre;
    issue(3);
    pre = m_q[1];
    send_rsp(m_q[2]);
    tick();
    drive_idle();
    core_q_valid_i = 1'b1;
    rand_req();
    rst_ni = 1'b0;
    #1;
    model_reset();
    total++;
    if (core_p_valid_o !== 1'b0 || outstanding_o !== '0 || err_o !== 1'b0 ||
        acc_req_o.p_ready !== 1'b1 || acc_req_o.q_valid !== 1'b1 || acc_req_o.q.id !== 5'd0) begin
      bad++;
      $display("FAIL rstmid_state got pv=%0b out=%0d err=%0b pr=%0b qv=%0b id=%0d want 0/0/0/1/1/0",
               core_p_valid_o, outstanding_o, err_o, acc_req_o.p_ready, acc_req_o.q_valid, acc_req_o.q.id);
    end
    tick();
    drive_idle();
    rst_ni = 1'b1;
    send_rsp(pre);
    tick();
    drive_idle();
    #1;
    total++;
    if (err_o !== 1'b1 || core_p_valid_o !== 1'b0 || outstanding_o !== '0) begin
      bad++;
      $display("FAIL rstmid_late got err=%0b pv=%0b out=%0d want 1/0/0", err_o, core_p_valid_o, outstanding_o);
    end
    core_q_valid_i = 1'b1;
    rand_req();
    #1;
    total++;
    if (acc_req_o.q.id !== 5'd0 || core_q_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_newid got id=%0d rdy=%0b want 0/1", acc_req_o.q.id, core_q_ready_o);
    end
    tick();
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_out_of_order();
    test_full_wrap();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
